// File: rtl/fifo_drain_if.sv
// fifo_drain_if: FIFO-side and stream-side signals of the drain stage.
//   fifo_empty/fifo_data/fifo_pop : show-ahead FIFO read port
//   flush                         : synchronous discard of buffered words
//   out_valid/out_ready/out_data  : valid/ready output stream
//   drain_count                   : delivered-word counter (DRAIN_CNT_EN only)
// slave is the drain stage's view; master is the environment's view.
interface fifo_drain_if #(
    parameter int WIDTH = 8
`ifdef DRAIN_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef DRAIN_CNT_EN
    logic [CNT_W-1:0] drain_count;
`endif

    modport slave (
        input  fifo_empty, fifo_data, flush, out_ready,
        output fifo_pop, out_valid, out_data
`ifdef DRAIN_CNT_EN
        ,
        output drain_count
`endif
    );

    modport master (
        output fifo_empty, fifo_data, flush, out_ready,
        input  fifo_pop, out_valid, out_data
`ifdef DRAIN_CNT_EN
        ,
        input  drain_count
`endif
    );
endinterface

// File: rtl/fifo_drain_stage.sv
// fifo_drain_stage: pops a show-ahead FIFO into a 2-entry skid buffer driving a valid/ready stream.
//   clk_i  : clock, all state on posedge
//   rst_ni : asynchronous active-low reset
//   bus    : fifo_drain_if.slave (FIFO read port, flush, output stream, optional drain_count)
// Optional feature macro DRAIN_CNT_EN adds the wrapping drain_count counter.
module fifo_drain_stage #(
    parameter int WIDTH = 8
`ifdef DRAIN_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input logic         clk_i,
    input logic         rst_ni,
    fifo_drain_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic             pop, deq;

    // pop looks only at registered occupancy and FIFO flags, so out_ready never reaches fifo_pop
    assign pop           = !bus.flush && !bus.fifo_empty && (occ_q != TWO);
    assign deq           = (occ_q != EMPTY) && bus.out_ready;
    assign bus.fifo_pop  = rst_ni && pop;
    assign bus.out_valid = (occ_q != EMPTY);
    assign bus.out_data  = entry0_q;

    always_comb begin
        occ_d    = occ_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        case (occ_q)
            EMPTY: if (pop) begin
                occ_d    = ONE;
                entry0_d = bus.fifo_data;
            end
            ONE: begin
                if (pop && deq) begin
                    entry0_d = bus.fifo_data;
                end else if (pop) begin
                    occ_d    = TWO;
                    entry1_d = bus.fifo_data;
                end else if (deq) begin
                    occ_d    = EMPTY;
                end
            end
            TWO: if (deq) begin
                occ_d    = ONE;
                entry0_d = entry1_q;
            end
            default: occ_d = EMPTY;
        endcase
        if (bus.flush) occ_d = EMPTY;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q    <= EMPTY;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            occ_q    <= occ_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
        end
    end

`ifdef DRAIN_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // a deq in a flush cycle still counts; flush never clears the counter
    assign cnt_d           = cnt_q + CNT_W'(deq);
    assign bus.drain_count = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_fifo_drain_stage.sv
// tb_fifo_drain_stage: directed vector table, corner sequences and randomized run against a queue model.
module tb_fifo_drain_stage;
    localparam int W = 8;
`ifdef DRAIN_CNT_EN
    localparam int CW = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef DRAIN_CNT_EN
    fifo_drain_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    fifo_drain_stage #(.WIDTH(W), .CNT_W(CW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
`else
    fifo_drain_if #(.WIDTH(W)) bus ();
    fifo_drain_stage #(.WIDTH(W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
`endif

    typedef struct {
        bit         pe;
        logic [7:0] pv;
        bit         fl;
        bit         rd;
        bit         ep;
        bit         ev;
        logic [7:0] ed;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] fq[$];
    logic [7:0] mb[$];
    int         cnt = 0;
    int         pass_n = 0;
    int         total_n = 0;
    logic       a_pop, a_v;
    logic [7:0] a_d;

    task automatic chk(input string nm, input int act, input int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic void add(bit pe, logic [7:0] pv, bit fl, bit rd, bit ep, bit ev, logic [7:0] ed);
        vec_t v;
        v.pe = pe; v.pv = pv; v.fl = fl; v.rd = rd; v.ep = ep; v.ev = ev; v.ed = ed;
        tbl.push_back(v);
    endfunction

    // One clock cycle: drive inputs, compare against the queue model at negedge, advance model at posedge.
    task automatic cycle(input bit pe, input logic [7:0] pv, input bit fl, input bit rd, input bit rn);
        bit         ep, ev;
        logic [7:0] ed;
        if (pe) fq.push_back(pv);
        rst_n          = rn;
        bus.flush      = fl;
        bus.out_ready  = rd;
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_data  = (fq.size() != 0) ? fq[0] : 8'($urandom);
        ep = rn && !fl && (fq.size() != 0) && (mb.size() < 2);
        ev = rn && (mb.size() != 0);
        ed = ev ? mb[0] : 8'h00;
        @(negedge clk);
        a_pop = bus.fifo_pop;
        a_v   = bus.out_valid;
        a_d   = bus.out_data;
        chk("fifo_pop", int'(a_pop), int'(ep));
        chk("out_valid", int'(a_v), int'(ev));
        if (ev || !rn) chk("out_data", int'(a_d), int'(ed));
`ifdef DRAIN_CNT_EN
        chk("drain_count", int'(bus.drain_count), cnt % (1 << CW));
`endif
        @(posedge clk);
        if (!rn) begin
            fq.delete();
            mb.delete();
            cnt = 0;
        end else begin
            if (ev && rd) begin
                cnt++;
                void'(mb.pop_front());
            end
            if (fl) mb.delete();
            else if (ep) mb.push_back(fq.pop_front());
        end
        #1;
    endtask

    initial begin
        bus.flush = 0; bus.out_ready = 0; bus.fifo_empty = 1; bus.fifo_data = 0;
        // reset with a non-empty FIFO: nothing popped, outputs zero
        fq.push_back(8'h77);
        cycle(0, 0, 0, 1, 0);
        chk("rst_pop", int'(a_pop), 0);
        chk("rst_valid", int'(a_v), 0);
        chk("rst_data", int'(a_d), 0);
        cycle(0, 0, 0, 1, 1);

        // latency
        add(1, 8'hA5, 0, 1, 1, 0, 0); add(0, 0, 0, 1, 0, 1, 8'hA5); add(0, 0, 0, 1, 0, 0, 0);
        // backpressure then drain in order
        add(1, 8'h01, 0, 0, 1, 0, 0);     add(1, 8'h02, 0, 0, 1, 1, 8'h01);
        add(1, 8'h03, 0, 0, 0, 1, 8'h01); add(1, 8'h04, 0, 0, 0, 1, 8'h01);
        add(0, 0, 0, 1, 0, 1, 8'h01);     add(0, 0, 0, 1, 1, 1, 8'h02);
        add(0, 0, 0, 1, 1, 1, 8'h03);     add(0, 0, 0, 1, 0, 1, 8'h04);
        add(0, 0, 0, 1, 0, 0, 0);
        // flush while holding two words
        add(1, 8'h10, 0, 0, 1, 0, 0);     add(1, 8'h11, 0, 0, 1, 1, 8'h10);
        add(1, 8'h12, 1, 0, 0, 1, 8'h10); add(0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 8'h12);     add(0, 0, 0, 1, 0, 0, 0);
        foreach (tbl[i]) begin
            cycle(tbl[i].pe, tbl[i].pv, tbl[i].fl, tbl[i].rd, 1);
            chk($sformatf("vec%0d_pop", i), int'(a_pop), int'(tbl[i].ep));
            chk($sformatf("vec%0d_valid", i), int'(a_v), int'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("vec%0d_data", i), int'(a_d), int'(tbl[i].ed));
        end

        // streaming: 8 queued words leave on 8 consecutive cycles
        for (int i = 0; i < 8; i++) fq.push_back(8'(8'h20 + i));
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 1, 1);
            chk($sformatf("stream%0d_valid", i), int'(a_v), int'(i >= 1 && i <= 8));
            if (i >= 1 && i <= 8) chk($sformatf("stream%0d_data", i), int'(a_d), 8'h20 + i - 1);
        end

        // reset in the middle of operation loses buffered words
        cycle(1, 8'h31, 0, 0, 1);
        cycle(1, 8'h32, 0, 0, 1);
        cycle(1, 8'h33, 0, 0, 0);
        chk("midrst_valid", int'(a_v), 0);
        cycle(0, 0, 0, 1, 1);

`ifdef DRAIN_CNT_EN
        // 17 deliveries wrap a 4-bit counter to 1; a flush leaves it untouched
        for (int i = 0; i < 17; i++) fq.push_back(8'(8'h40 + i));
        for (int i = 0; i < 19; i++) cycle(0, 0, 0, 1, 1);
        @(negedge clk);
        chk("cnt_wrap", int'(bus.drain_count), 1);
        #1;
        cycle(1, 8'h51, 0, 0, 1);
        cycle(1, 8'h52, 0, 0, 1);
        cycle(0, 0, 1, 0, 1);
        @(negedge clk);
        chk("cnt_flush", int'(bus.drain_count), 1);
        #1;
`endif

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++)
            cycle(bit'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
